cluster_rate_monitor: RTL and testbench
=======================================

# cluster_rate_monitor

Windowed occupancy monitor that sits directly downstream of the cluster counter. Each `clock4x` cycle it consumes the per-cycle cluster count and overflow flag. It accumulates them over fixed windows of 2^WINDOW_LOG2 samples aligned to `bx0_i`, then publishes the window sum, the overflow-cycle tally and, optionally, the peak count to slow control. It is a statistics path only and never back-pressures the trigger datapath.

## Interface
Parameters:
- WINDOW_LOG2, 12, log2 of samples per window (1..20).
- SUM_W, 24, width of the window-sum accumulator and output.
- OVF_W, 16, width of the overflow-cycle counter and output.

Ports:
- clock4x  in  1  sole clock, 4x LHC clock.
- reset  in  1  synchronous, active-high.
- enable_i  in  1  level; monitor runs while high.
- bx0_i  in  1  orbit-marker pulse, same cycle as the sample it tags.
- cnt_i  in  11  cluster count of the current cycle.
- overflow_i  in  1  overflow flag of the current cycle.
- sum_o  out  SUM_W  sum of cnt_i over the last completed window.
- ovf_cnt_o  out  OVF_W  number of cycles with overflow_i=1 in the last window.
- peak_o  out  11  maximum cnt_i in the last window (only with CLUSTER_PEAK_EN).
- sat_o  out  1  sum or ovf counter saturated in the last window.
- window_done_o  out  1  one-cycle pulse when the outputs update.
- state_o  out  2  current FSM state, for debug.

## Operation
- Input stage: cnt_i, overflow_i and bx0_i are registered once (stage A). All further logic uses stage A.
- FSM states: IDLE=0, ARM=1, RUN=2.
  - IDLE: accumulators are cleared. enable_i=1 moves to ARM.
  - ARM: waits for bx0 in stage A. That sample becomes sample 0 of the first window, and the FSM moves to RUN.
  - RUN: accumulates every cycle. bx0 is ignored in RUN.
- Any cycle with enable_i=0 goes to IDLE from any state. The partial window is discarded, no done pulse is issued, and the outputs hold their last values.
- Sample counter: WINDOW_LOG2 bits, wraps naturally.
  - Sample 0 of every window loads the accumulators: sum = cnt, ovf = overflow, peak = cnt. It does not add to the previous value.
  - All other samples add, with saturation. The sum saturates at 2^SUM_W-1 and ovf at 2^OVF_W-1. A sticky sat bit is set in the window on any saturation.
- Windows run back-to-back with no dead cycle. When the last sample (index 2^WINDOW_LOG2-1) is accumulated, sum/ovf/peak/sat are copied into the output registers and window_done_o pulses.
- Widths: cnt is zero-extended to SUM_W before the add. The peak compare is unsigned 11-bit.

## Timing
- Reset values: sum_o=0, ovf_cnt_o=0, peak_o=0, sat_o=0, window_done_o=0, state_o=IDLE. All internal accumulators and the sample counter are 0.
- Reset mid-window: the FSM returns to IDLE on the next edge and the partial data is lost. Reset has priority over enable_i.
- Latency: if the final sample of a window is on cnt_i at edge N, then at edge N+2 the outputs are updated and window_done_o=1 for exactly one cycle.
- enable_i rising at edge E: the FSM is ARM after E. The earliest window start is a bx0 on the inputs at edge E+1.
- bx0 in the same stage-A cycle that the FSM enters ARM is not used. Alignment requires ARM to be already held.
- The outputs are stable between done pulses. Slow control must sample them on window_done_o or while they are quiescent.

## Configuration
- CLUSTER_PEAK_EN defined: the peak register is built, and peak_o reports the window maximum.
- CLUSTER_PEAK_EN undefined: peak_o is tied to 0 and the peak register and comparator are removed. The port list is unchanged.

## Structure
- Package cluster_monitor_pkg holds:
  - the state enum (IDLE/ARM/RUN, 2 bits);
  - CNT_W=11;
  - the default widths.
- Sub-module sat_accum (parameter W) performs the load-or-add with saturation and sets the sticky sat bit. It is instantiated for the sum and for the ovf counter.
- The FSM, sample counter, peak logic and output registers stay in the top module.

## Test plan
All scenarios use WINDOW_LOG2=2.
- Enable, bx0 on first sample, cnt 3,5,0,9 with overflow 0,0,0,1 -> one done pulse 2 edges after the 9. sum_o=17, ovf_cnt_o=1, peak_o=9, sat_o=0.
- Continuous cnt 1..8 from bx0 -> two done pulses 4 cycles apart: sum_o=10, then sum_o=26, with peak_o 4, then 8.
- SUM_W=4, cnt 10,10,1,1 -> sum_o=15, sat_o=1. The next window 1,1,1,1 -> sum_o=4, sat_o=0.
- enable_i dropped after 2 samples of a window -> no done pulse, outputs keep prior values, state_o=IDLE. Re-enable without bx0 -> stays ARM, no pulse.
- Reset asserted mid-window with prior results present -> all outputs 0 on the next cycle, state_o=IDLE.
- Build without CLUSTER_PEAK_EN, stimulus as scenario 1 -> peak_o=0, other outputs identical to scenario 1.

Source files
------------

// File: rtl/cluster_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cluster_monitor_pkg
// Shared definitions for the cluster rate monitor:
//   - CNT_W          width of the per-cycle cluster count
//   - DEF_*          default window / accumulator widths
//   - mon_state_e    monitor FSM state encoding (IDLE=0, ARM=1, RUN=2)
// -----------------------------------------------------------------------------
package cluster_monitor_pkg;

  localparam int CNT_W           = 11;
  localparam int DEF_WINDOW_LOG2 = 12;
  localparam int DEF_SUM_W       = 24;
  localparam int DEF_OVF_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/sat_accum.sv
// -----------------------------------------------------------------------------
// sat_accum
// Load-or-add accumulator with saturation and a sticky saturation flag.
//   clock4x  clock
//   reset    synchronous active-high reset
//   clear    synchronous clear (same effect as reset)
//   en       accumulate this cycle
//   load     first sample of a window: replace instead of add
//   din      unsigned input, zero-extended to the accumulator width
//   acc_o    accumulator value, saturates at 2^W-1
//   sat_o    set on any saturation since the last load
// -----------------------------------------------------------------------------
module sat_accum #(
  parameter int W     = 16,
  parameter int DIN_W = 11
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [DIN_W-1:0] din,
  output logic [W-1:0]     acc_o,
  output logic             sat_o
);

  // One spare bit above the wider operand, so the carry (or an input that is
  // already wider than the accumulator) is visible to the compare.
  localparam int EW = ((W > DIN_W) ? W : DIN_W) + 1;
  localparam logic [EW-1:0] MAX_EXT = {{(EW-W){1'b0}}, {W{1'b1}}};

  logic [EW-1:0] base;
  logic [EW-1:0] sum_ext;
  logic          over;

  always_comb begin
    base    = load ? '0 : EW'(acc_o);
    sum_ext = base + EW'(din);
    over    = (sum_ext > MAX_EXT);
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock4x) begin
    if (reset || clear) begin
      acc_o <= '0;
      sat_o <= 1'b0;
    end else if (en) begin
      acc_o <= over ? '1 : sum_ext[W-1:0];
      sat_o <= over | (sat_o & ~load);
    end
  end

endmodule

// File: rtl/cluster_rate_monitor.sv
// -----------------------------------------------------------------------------
// cluster_rate_monitor
// Windowed occupancy monitor downstream of the cluster counter. Accumulates
// cluster counts and overflow cycles over 2^WINDOW_LOG2 samples aligned to
// bx0 and publishes the results with a one-cycle done pulse.
// Build option: define CLUSTER_PEAK_EN to build the window peak register;
// otherwise peak_o is tied to 0.
//   clock4x        clock (4x LHC)
//   reset          synchronous active-high reset
//   enable_i       monitor runs while high
//   bx0_i          orbit marker, tags the sample of the same cycle
//   cnt_i          cluster count of the current cycle
//   overflow_i     overflow flag of the current cycle
//   sum_o          sum of cnt over the last completed window (saturating)
//   ovf_cnt_o      overflow-cycle tally of the last window (saturating)
//   peak_o         maximum cnt of the last window (CLUSTER_PEAK_EN only)
//   sat_o          a saturation happened in the last window
//   window_done_o  one-cycle pulse when the outputs update
//   state_o        FSM state, debug only
// -----------------------------------------------------------------------------
module cluster_rate_monitor
  import cluster_monitor_pkg::*;
#(
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int SUM_W       = DEF_SUM_W,
  parameter int OVF_W       = DEF_OVF_W
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             bx0_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             overflow_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [OVF_W-1:0] ovf_cnt_o,
  output logic [CNT_W-1:0] peak_o,
  output logic             sat_o,
  output logic             window_done_o,
  output logic [1:0]       state_o
);

  // Stage A: every downstream decision uses these registered copies.
  logic [CNT_W-1:0] cnt_a;
  logic             ovf_a;
  logic             bx0_a;

  always_ff @(posedge clock4x) begin
    if (reset) begin
      cnt_a <= '0;
      ovf_a <= 1'b0;
      bx0_a <= 1'b0;
    end else begin
      cnt_a <= cnt_i;
      ovf_a <= overflow_i;
      bx0_a <= bx0_i;
    end
  end

  mon_state_e             state_q, state_d;
  logic                   arm_held_q;   // FSM was already in ARM last cycle
  logic [WINDOW_LOG2-1:0] idx_q;        // sample index inside the window
  logic                   acc_en;
  logic                   acc_clear;
  logic                   sample0;
  logic                   last;
  logic                   publish_q;

  // State register
  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q    <= IDLE;
      arm_held_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_held_q <= (state_q == ARM);
    end
  end

  // Next state. A bx0 that arrives together with the entry into ARM is
  // ignored: alignment only counts once ARM has been held for a cycle.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (bx0_a && arm_held_q) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  // NOTE: each signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_en    = 1'b0;
    acc_clear = 1'b0;
    case (state_q)
      IDLE:    acc_clear = 1'b1;
      ARM:     acc_en    = enable_i && bx0_a && arm_held_q;
      RUN:     acc_en    = enable_i;
      default: acc_clear = 1'b1;
    endcase
  end

  assign state_o = state_q;

  // The index is held at 0 in IDLE/ARM, so the aligning sample is sample 0.
  assign sample0 = (idx_q == '0);
  assign last    = &idx_q;

  always_ff @(posedge clock4x) begin
    if (reset || acc_clear) begin
      idx_q <= '0;
    end else if (acc_en) begin
      idx_q <= idx_q + WINDOW_LOG2'(1);
    end
  end

  logic [SUM_W-1:0] sum_acc;
  logic [OVF_W-1:0] ovf_acc;
  logic             sum_sat;
  logic             ovf_sat;

  sat_accum #(.W(SUM_W), .DIN_W(CNT_W)) u_sum (
    .clock4x (clock4x),
    .reset   (reset),
    .clear   (acc_clear),
    .en      (acc_en),
    .load    (sample0),
    .din     (cnt_a),
    .acc_o   (sum_acc),
    .sat_o   (sum_sat)
  );

  sat_accum #(.W(OVF_W), .DIN_W(1)) u_ovf (
    .clock4x (clock4x),
    .reset   (reset),
    .clear   (acc_clear),
    .en      (acc_en),
    .load    (sample0),
    .din     (ovf_a),
    .acc_o   (ovf_acc),
    .sat_o   (ovf_sat)
  );

  // The last sample lands in the accumulators one edge before the copy, so
  // the copy reads complete values while sample 0 of the next window loads.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      publish_q     <= 1'b0;
      window_done_o <= 1'b0;
      sum_o         <= '0;
      ovf_cnt_o     <= '0;
      sat_o         <= 1'b0;
    end else begin
      publish_q     <= acc_en && last;
      window_done_o <= publish_q;
      if (publish_q) begin
        sum_o     <= sum_acc;
        ovf_cnt_o <= ovf_acc;
        sat_o     <= sum_sat | ovf_sat;
      end
    end
  end

`ifdef CLUSTER_PEAK_EN
  logic [CNT_W-1:0] peak_q;

  always_ff @(posedge clock4x) begin
    if (reset || acc_clear) begin
      peak_q <= '0;
    end else if (acc_en && (sample0 || (cnt_a > peak_q))) begin
      peak_q <= cnt_a;
    end
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      peak_o <= '0;
    end else if (publish_q) begin
      peak_o <= peak_q;
    end
  end
`else
  assign peak_o = '0;
`endif

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// -----------------------------------------------------------------------------
// tb_cluster_rate_monitor
// Two monitors share the stimulus: dut_a with wide accumulators, dut_b with
// SUM_W=4 / OVF_W=2 so saturation happens often. Both use 4-sample windows.
// The reference model keeps the window's samples in queues and derives the
// published values with plain sums, min and max.
// -----------------------------------------------------------------------------
module tb_cluster_rate_monitor;

  localparam int WL    = 2;
  localparam int WIN   = 1 << WL;
  localparam int MAX_A = (1 << 24) - 1;
  localparam int MAXO_A = (1 << 16) - 1;
  localparam int MAX_B = 15;
  localparam int MAXO_B = 3;

`ifdef CLUSTER_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic        clock4x = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        bx0_i;
  logic [10:0] cnt_i;
  logic        overflow_i;

  logic [23:0] sum_a;
  logic [15:0] ovf_a;
  logic [10:0] peak_a;
  logic        sat_a, done_a;
  logic [1:0]  state_a;

  logic [3:0]  sum_b;
  logic [1:0]  ovf_b;
  logic [10:0] peak_b;
  logic        sat_b, done_b;
  logic [1:0]  state_b;

  always #5 clock4x = ~clock4x;

  cluster_rate_monitor #(.WINDOW_LOG2(WL), .SUM_W(24), .OVF_W(16)) dut_a (
    .clock4x       (clock4x),
    .reset         (reset),
    .enable_i      (enable_i),
    .bx0_i         (bx0_i),
    .cnt_i         (cnt_i),
    .overflow_i    (overflow_i),
    .sum_o         (sum_a),
    .ovf_cnt_o     (ovf_a),
    .peak_o        (peak_a),
    .sat_o         (sat_a),
    .window_done_o (done_a),
    .state_o       (state_a)
  );

  cluster_rate_monitor #(.WINDOW_LOG2(WL), .SUM_W(4), .OVF_W(2)) dut_b (
    .clock4x       (clock4x),
    .reset         (reset),
    .enable_i      (enable_i),
    .bx0_i         (bx0_i),
    .cnt_i         (cnt_i),
    .overflow_i    (overflow_i),
    .sum_o         (sum_b),
    .ovf_cnt_o     (ovf_b),
    .peak_o        (peak_b),
    .sat_o         (sat_b),
    .window_done_o (done_b),
    .state_o       (state_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st;            // 0 idle, 1 arm, 2 run
  int m_arm_age;       // cycles spent in ARM before this one
  int p_cnt;           // sample seen on the previous edge
  bit p_ovf, p_bx0;
  int win_c[$];
  int win_o[$];
  bit pend;
  int pd_sum_a, pd_ovf_a, pd_sat_a, pd_sum_b, pd_ovf_b, pd_sat_b, pd_peak;
  int e_sum_a, e_ovf_a, e_sat_a, e_sum_b, e_ovf_b, e_sat_b, e_peak, e_done;

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_arm_age = 0;
    p_cnt = 0; p_ovf = 0; p_bx0 = 0;
    win_c.delete(); win_o.delete();
    pend = 0;
    e_sum_a = 0; e_ovf_a = 0; e_sat_a = 0;
    e_sum_b = 0; e_ovf_b = 0; e_sat_b = 0;
    e_peak = 0; e_done = 0;
  endtask

  task automatic close_window();
    int tot, tov, pk;
    tot = 0; tov = 0; pk = 0;
    foreach (win_c[i]) begin
      tot += win_c[i];
      tov += win_o[i];
      if (win_c[i] > pk) pk = win_c[i];
    end
    pd_sum_a = clamp(tot, MAX_A);
    pd_ovf_a = clamp(tov, MAXO_A);
    pd_sat_a = (tot > MAX_A || tov > MAXO_A) ? 1 : 0;
    pd_sum_b = clamp(tot, MAX_B);
    pd_ovf_b = clamp(tov, MAXO_B);
    pd_sat_b = (tot > MAX_B || tov > MAXO_B) ? 1 : 0;
    pd_peak  = PEAK_ON ? pk : 0;
    pend = 1;
    win_c.delete();
    win_o.delete();
  endtask

  task automatic model_step(input bit rst, input bit en, input bit b, input int c, input bit o);
    if (rst) begin
      model_reset();
      return;
    end
    e_done = pend ? 1 : 0;
    if (pend) begin
      e_sum_a = pd_sum_a; e_ovf_a = pd_ovf_a; e_sat_a = pd_sat_a;
      e_sum_b = pd_sum_b; e_ovf_b = pd_ovf_b; e_sat_b = pd_sat_b;
      e_peak  = pd_peak;
    end
    pend = 0;
    if (!en) begin
      m_st = 0;
      win_c.delete();
      win_o.delete();
    end else if (m_st == 0) begin
      m_st = 1;
      m_arm_age = 0;
    end else if (m_st == 1) begin
      if (p_bx0 && m_arm_age > 0) begin
        m_st = 2;
        win_c.push_back(p_cnt);
        win_o.push_back(int'(p_ovf));
      end else begin
        m_arm_age++;
      end
    end else begin
      win_c.push_back(p_cnt);
      win_o.push_back(int'(p_ovf));
    end
    if (win_c.size() == WIN) close_window();
    p_cnt = c; p_ovf = o; p_bx0 = b;
  endtask

  task automatic compare_all();
    check("done_a",  32'(done_a),  e_done);
    check("state_a", 32'(state_a), m_st);
    check("sum_a",   32'(sum_a),   e_sum_a);
    check("ovf_a",   32'(ovf_a),   e_ovf_a);
    check("sat_a",   32'(sat_a),   e_sat_a);
    check("peak_a",  32'(peak_a),  e_peak);
    check("done_b",  32'(done_b),  e_done);
    check("state_b", 32'(state_b), m_st);
    check("sum_b",   32'(sum_b),   e_sum_b);
    check("ovf_b",   32'(ovf_b),   e_ovf_b);
    check("sat_b",   32'(sat_b),   e_sat_b);
    check("peak_b",  32'(peak_b),  e_peak);
  endtask

  task automatic tick(input bit rst, input bit en, input bit b, input int c, input bit o);
    reset = rst; enable_i = en; bx0_i = b; cnt_i = 11'(c); overflow_i = o;
    @(posedge clock4x);
    model_step(rst, en, b, c, o);
    #1;
    compare_all();
  endtask

  int s3[10] = '{10, 10, 1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    bit r_rst, r_en, r_b, r_o;
    int r_c;
    model_reset();
    reset = 1'b1; enable_i = 1'b0; bx0_i = 1'b0; cnt_i = '0; overflow_i = 1'b0;

    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check("rst_sum",   32'(sum_a),   0);
    check("rst_state", 32'(state_a), 0);
    check("rst_done",  32'(done_a),  0);
    tick(0, 0, 0, 0, 0);

    // Window 3,5,0,9 aligned to the earliest usable bx0.
    tick(0, 1, 0, 0, 0);
    check("s1_arm", 32'(state_a), 1);
    tick(0, 1, 1, 3, 0);
    tick(0, 1, 0, 5, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 9, 1);
    tick(0, 1, 0, 0, 0);
    check("s1_done_early", 32'(done_a), 0);
    tick(0, 1, 0, 0, 0);
    check("s1_done", 32'(done_a), 1);
    check("s1_sum",  32'(sum_a),  17);
    check("s1_ovf",  32'(ovf_a),  1);
    check("s1_peak", 32'(peak_a), PEAK_ON ? 9 : 0);
    check("s1_sat",  32'(sat_a),  0);

    // Two samples into the next window: drop enable, then re-arm without bx0.
    tick(0, 0, 0, 0, 0);
    check("s4_done",  32'(done_a),  0);
    check("s4_state", 32'(state_a), 0);
    tick(0, 0, 0, 0, 0);
    check("s4_hold_sum", 32'(sum_a), 17);
    for (int i = 0; i < 6; i++) tick(0, 1, 0, 2, 0);
    check("s4_arm_state", 32'(state_a), 1);
    check("s4_arm_done",  32'(done_a),  0);

    // Counts 1..8 from bx0; the extra bx0 on 5 must be ignored in RUN.
    for (int i = 1; i <= 8; i++) begin
      tick(0, 1, (i == 1 || i == 5), i, 0);
      if (i == 6) begin
        check("s2_w1_done", 32'(done_a), 1);
        check("s2_w1_sum",  32'(sum_a),  10);
        check("s2_w1_peak", 32'(peak_a), PEAK_ON ? 4 : 0);
      end
    end

    // Saturating windows on dut_b, back-to-back after the 1..8 run.
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, s3[i], 0);
      if (i == 1) begin
        check("s2_w2_done", 32'(done_a), 1);
        check("s2_w2_sum",  32'(sum_a),  26);
        check("s2_w2_peak", 32'(peak_a), PEAK_ON ? 8 : 0);
      end
      if (i == 5) begin
        check("s3_w1_sum", 32'(sum_b), 15);
        check("s3_w1_sat", 32'(sat_b), 1);
      end
      if (i == 9) begin
        check("s3_w2_done", 32'(done_b), 1);
        check("s3_w2_sum",  32'(sum_b),  4);
        check("s3_w2_sat",  32'(sat_b),  0);
      end
    end

    // Reset in the middle of a window with results present.
    tick(0, 1, 0, 7, 1);
    tick(1, 1, 0, 7, 1);
    check("s5_sum",   32'(sum_a),   0);
    check("s5_ovf",   32'(ovf_a),   0);
    check("s5_sat",   32'(sat_b),   0);
    check("s5_state", 32'(state_a), 0);
    check("s5_done",  32'(done_a),  0);
    tick(0, 0, 0, 0, 0);

    // Randomized traffic.
    r_en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      if (r_en) r_en = ($urandom_range(0, 149) != 0);
      else      r_en = ($urandom_range(0, 4) == 0);
      r_b = ($urandom_range(0, 9) == 0);
      r_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 5));
      r_o = ($urandom_range(0, 3) == 0);
      tick(r_rst, r_en, r_b, r_c, r_o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
